// File: rtl/fp_regfile_scoreboard_if.sv
// Issue/writeback/read bundle of the FP register file with busy scoreboard.
// The master modport is the issue/FPU side; the slave modport is the register file.
interface fp_regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);
    localparam int CNT_WIDTH  = $clog2(NUM_REGS + 1);

    logic                  write_En;
    logic [ADDR_WIDTH-1:0] writeAddr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] addr_A;
    logic [ADDR_WIDTH-1:0] addr_B;
    logic [DATA_WIDTH-1:0] data_outA;
    logic [DATA_WIDTH-1:0] data_outB;
    logic                  busy_A;
    logic                  busy_B;
    logic                  rsv_En;
    logic [ADDR_WIDTH-1:0] rsv_Addr;
    logic                  rsv_Ack;
    logic                  rsv_Err;
    logic [CNT_WIDTH-1:0]  busy_Count;

    modport master (
        output write_En, writeAddr, data_in, addr_A, addr_B, rsv_En, rsv_Addr,
        input  data_outA, data_outB, busy_A, busy_B, rsv_Ack, rsv_Err, busy_Count
    );

    modport slave (
        input  write_En, writeAddr, data_in, addr_A, addr_B, rsv_En, rsv_Addr,
        output data_outA, data_outB, busy_A, busy_B, rsv_Ack, rsv_Err, busy_Count
    );
endinterface

// File: rtl/fp_regfile_scoreboard.sv
// FP register file: two combinational read ports, one synchronous write port and a
// per-register busy scoreboard. Issue reserves a destination (sets busy), writeback
// writes data and clears busy; reads report busy so issue can stall on RAW hazards.
// Optional write-to-read forwarding is enabled by defining FP_REGFILE_BYPASS_EN.
module fp_regfile_scoreboard #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    fp_regfile_scoreboard_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);
    localparam int CNT_WIDTH  = $clog2(NUM_REGS + 1);
    localparam logic [ADDR_WIDTH:0] NREGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  wr_ok_s, rsv_ok_s, same_s;
    logic [DATA_WIDTH-1:0] data_a_s, data_b_s;
    logic                  busy_a_s, busy_b_s;

    // Address lies inside the implemented register range (matters for non power-of-2 sizes).
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < NREGS_W);
    endfunction

    assign wr_ok_s  = bus.write_En && in_range(bus.writeAddr);
    assign rsv_ok_s = bus.rsv_En && in_range(bus.rsv_Addr);
    assign same_s   = wr_ok_s && (bus.writeAddr == bus.rsv_Addr);

    // Scoreboard next state: a write clears busy first, then an accepted reserve sets it,
    // so a same-cycle write+reserve to one register leaves the new producer pending.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        if (wr_ok_s) begin
            busy_d[bus.writeAddr] = 1'b0;
            if (busy_q[bus.writeAddr]) begin
                count_d = count_d - CNT_WIDTH'(1'b1);
            end else begin
                count_d = count_d;
            end
        end else begin
            busy_d = busy_d;
        end
        if (rsv_ok_s) begin
            if (!busy_q[bus.rsv_Addr] || same_s) begin
                busy_d[bus.rsv_Addr] = 1'b1;
                ack_d                = 1'b1;
                count_d              = count_d + CNT_WIDTH'(1'b1);
            end else begin
                err_d = 1'b1;
            end
        end else begin
            ack_d = 1'b0;
        end
    end

    // Scoreboard, busy counter and reservation response registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Register array: cleared on reset, written by the writeback port.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok_s) begin
            regs_q[bus.writeAddr] <= bus.data_in;
        end
    end

    // Read port A: array lookup, zero for out-of-range, optional forwarding of the write.
    always_comb begin
        data_a_s = '0;
        busy_a_s = 1'b0;
        if (in_range(bus.addr_A)) begin
            data_a_s = regs_q[bus.addr_A];
            busy_a_s = busy_q[bus.addr_A];
        end else begin
            data_a_s = '0;
        end
`ifdef FP_REGFILE_BYPASS_EN
        if (wr_ok_s && (bus.addr_A == bus.writeAddr)) begin
            data_a_s = bus.data_in;
            busy_a_s = 1'b0;
        end else begin
            busy_a_s = busy_a_s;
        end
`endif
    end

    // Read port B: same behaviour as port A.
    always_comb begin
        data_b_s = '0;
        busy_b_s = 1'b0;
        if (in_range(bus.addr_B)) begin
            data_b_s = regs_q[bus.addr_B];
            busy_b_s = busy_q[bus.addr_B];
        end else begin
            data_b_s = '0;
        end
`ifdef FP_REGFILE_BYPASS_EN
        if (wr_ok_s && (bus.addr_B == bus.writeAddr)) begin
            data_b_s = bus.data_in;
            busy_b_s = 1'b0;
        end else begin
            busy_b_s = busy_b_s;
        end
`endif
    end

    assign bus.data_outA  = data_a_s;
    assign bus.data_outB  = data_b_s;
    assign bus.busy_A     = busy_a_s;
    assign bus.busy_B     = busy_b_s;
    assign bus.rsv_Ack    = ack_q;
    assign bus.rsv_Err    = err_q;
    assign bus.busy_Count = count_q;
endmodule
